tc_array: RTL
=============

Name: tc_array

Overview:
- Parametrised multi-channel timer/counter peripheral. Successor to the fixed two-instance timer pair on the bridge.
- Holds N_CH independent down-counters behind one word-addressed register window.
- Each channel runs in one-shot or auto-reload mode, with a sticky pending flag, an overrun flag and a maskable IRQ.
- Sits on the bridge device side; irq[] feeds the CPU HWInt vector.

Parameters:
- N_CH, 2: number of timer channels (1..16).
- CNT_W, 32: counter/preset width (1..32). Narrower values are zero-extended on read; upper write bits are ignored.
- ADDR_W, 6: word-address width; must be ≥ clog2(N_CH)+2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  word address within block; channel = addr[ADDR_W-1:2], register = addr[1:0]
- we  in  1  write strobe, sampled on clk rising edge
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- irq  out  N_CH  per-channel interrupt = pending & IM
- irq_any  out  1  OR of irq

Behaviour:
- Reset: clk and reset are as already decided (one clock; reset asynchronous, active-high). On reset, every CTRL, PRESET, COUNT, pending and overrun clears to 0, and all channel FSMs go to IDLE. Outputs therefore reset as irq=0, irq_any=0, and rdata = the selected register, i.e. 0. Reset mid-count aborts immediately.
- Register map per channel (word offset):
  - 0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved = one-shot), [3] IM.
  - 1 PRESET: R/W.
  - 2 COUNT: read-only.
  - 3 STATUS: [0] pending, [1] overrun; writing 1 clears the bit, writing 0 has no effect.
- Unimplemented CTRL bits read 0. A channel index ≥ N_CH reads 0 and ignores writes. A write to COUNT is ignored.
- FSM per channel: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - EN=0 → IDLE, COUNT holds.
    - Else if COUNT ≤ 1: COUNT ← 0, pending ← 1; if pending was already 1, overrun ← 1; → INT.
    - Else COUNT ← COUNT−1.
  - INT:
    - One-shot: EN ← 0; → IDLE.
    - Auto-reload: if EN, COUNT ← PRESET and → CNT; else → IDLE.
- Latency:
  - With PRESET=P≥1, pending sets on the (P+2)th rising edge after the edge that wrote EN=1. P=0 behaves as P=1.
  - Auto-reload period is P+1 cycles.
- A PRESET write during counting takes effect at the next LOAD/reload only.
- Simultaneous events:
  - W1C on STATUS in the same cycle pending is set: set wins.
  - A bus CTRL write in the same cycle as the one-shot EN auto-clear: the bus write wins.
  - A CTRL write with EN=0 in CNT: the counter still decrements on that edge, then holds.
- irq is registered-state derived (pending & IM), glitch-free. Clearing IM masks irq without clearing pending.

Optional Feature:
- Macro TC_PRESCALE_EN.
- When defined:
  - CTRL[11:4] is prescale PS.
  - Each channel has an 8-bit prescaler; COUNT decrements (and the ≤1 expiry check is evaluated) only on ticks every PS+1 cycles.
  - The prescaler clears in LOAD, on reload, and on reset.
- When undefined: CTRL[11:4] reads 0, writes are ignored, and ticks occur every cycle (identical to PS=0).

Test Plan:
- Reset mid-count (ch0 enabled, COUNT=3), then assert reset asynchronously between edges → irq, rdata(COUNT), CTRL all read 0 immediately, with no irq after release.
- Ch0 PRESET=5, CTRL=0b1001 (EN, one-shot, IM) → irq[0]=1 and irq_any=1 on edge 7 after the write. CTRL then reads 0x8 and COUNT reads 0. Write STATUS=1 → irq[0]=0 next cycle.
- Ch1 PRESET=3, CTRL=0b1011 (auto-reload) → pending every 4 cycles. Not clearing it → STATUS reads 0x3 after the second expiry. W1C 0x3 → 0.
- Ch0 W1C STATUS on the exact expiry edge → pending remains 1, irq stays high.
- Ch0 PRESET=10, enable, write CTRL=0 when COUNT=4 → COUNT freezes at 3. Re-enable → COUNT reloads to 10.
- IM=0 expiry → STATUS pending=1, irq=0. Write to addr with channel ≥ N_CH → no register changes, read returns 0. With TC_PRESCALE_EN and PS=1, P=2 → expiry on edge 6 after enable.

Source files
------------

// File: rtl/tc_array.sv
// tc_array: N_CH independent down-counting timers behind one word-addressed register window.
// Define TC_PRESCALE_EN to add an 8-bit per-channel prescaler controlled by CTRL[11:4].
module tc_array #(
    parameter int N_CH   = 2,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [N_CH-1:0]   irq,
    output logic              irq_any
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [ADDR_W-3:0] ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       rd_word [N_CH][4];

    assign ch_sel  = addr[ADDR_W-1:2];
    assign reg_sel = addr[1:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic             en_q, en_d, im_q, im_d;
        logic             pend_q, pend_d, ovr_q, ovr_d;
        logic [1:0]       mode_q, mode_d;
        logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
        logic             wr_hit, tick, expire;
`ifdef TC_PRESCALE_EN
        logic [7:0]       ps_q, ps_d, pscnt_q, pscnt_d;

        assign tick           = (pscnt_q >= ps_q);
        assign rd_word[i][0]  = {20'd0, ps_q, im_q, mode_q, en_q};
`else
        assign tick           = 1'b1;
        assign rd_word[i][0]  = {28'd0, im_q, mode_q, en_q};
`endif
        assign rd_word[i][1] = 32'(preset_q);
        assign rd_word[i][2] = 32'(count_q);
        assign rd_word[i][3] = {30'd0, ovr_q, pend_q};
        assign irq[i]        = pend_q & im_q;
        assign wr_hit        = we && (ch_sel == (ADDR_W-2)'(i));

        // Bus writes are applied after the FSM so a CTRL write beats the one-shot EN clear,
        // and expiry is applied last so a set of pending beats a same-cycle W1C.
        always_comb begin
            state_d  = state_q;
            en_d     = en_q;
            im_d     = im_q;
            mode_d   = mode_q;
            preset_d = preset_q;
            count_d  = count_q;
            pend_d   = pend_q;
            ovr_d    = ovr_q;
            expire   = 1'b0;
`ifdef TC_PRESCALE_EN
            ps_d     = ps_q;
            pscnt_d  = pscnt_q;
`endif
            case (state_q)
                IDLE: begin
                    if (en_q) state_d = LOAD;
                end
                LOAD: begin
                    count_d = preset_q;
                    state_d = CNT;
`ifdef TC_PRESCALE_EN
                    pscnt_d = '0;
`endif
                end
                CNT: begin
                    if (!en_q) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (count_q <= CNT_W'(1)) begin
                            count_d = '0;
                            expire  = 1'b1;
                            state_d = INT;
                        end else begin
                            count_d = count_q - CNT_W'(1);
                        end
`ifdef TC_PRESCALE_EN
                        pscnt_d = '0;
                    end else begin
                        pscnt_d = pscnt_q + 8'd1;
`endif
                    end
                end
                INT: begin
                    if (mode_q == 2'b01) begin
                        if (en_q) begin
                            count_d = preset_q;
                            state_d = CNT;
`ifdef TC_PRESCALE_EN
                            pscnt_d = '0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        en_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (wr_hit) begin
                case (reg_sel)
                    REG_CTRL: begin
                        en_d   = wdata[0];
                        mode_d = wdata[2:1];
                        im_d   = wdata[3];
`ifdef TC_PRESCALE_EN
                        ps_d   = wdata[11:4];
`endif
                    end
                    REG_PRESET: preset_d = wdata[CNT_W-1:0];
                    REG_STATUS: begin
                        if (wdata[0]) pend_d = 1'b0;
                        if (wdata[1]) ovr_d  = 1'b0;
                    end
                    default: ;
                endcase
            end

            if (expire) begin
                pend_d = 1'b1;
                if (pend_q) ovr_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= IDLE;
                en_q     <= 1'b0;
                im_q     <= 1'b0;
                mode_q   <= 2'b00;
                preset_q <= '0;
                count_q  <= '0;
                pend_q   <= 1'b0;
                ovr_q    <= 1'b0;
`ifdef TC_PRESCALE_EN
                ps_q     <= '0;
                pscnt_q  <= '0;
`endif
            end else begin
                state_q  <= state_d;
                en_q     <= en_d;
                im_q     <= im_d;
                mode_q   <= mode_d;
                preset_q <= preset_d;
                count_q  <= count_d;
                pend_q   <= pend_d;
                ovr_q    <= ovr_d;
`ifdef TC_PRESCALE_EN
                ps_q     <= ps_d;
                pscnt_q  <= pscnt_d;
`endif
            end
        end
    end

    // Channel indices with no implemented channel fall through to zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == (ADDR_W-2)'(i)) rdata = rd_word[i][reg_sel];
        end
    end

    assign irq_any = |irq;

endmodule
